i2c_frame_builder: RTL

Upstream feeder for the I2C byte-sequencing master (the block that transmits a 104-bit frame MSB byte first, address 0x07). It accepts payload bytes over a valid/ready stream and packs them MSB-first into a 104-bit frame. It appends an optional two's-complement checksum byte, then holds the frame stable and drives the master's enable until the master reports completion. Provides frame counting and a transmit-timeout error.

---
 rtl/i2c_frame_builder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/i2c_frame_builder.sv
// i2c_frame_builder
// Collects payload bytes from a valid/ready stream and packs them MSB byte
// first into a NUM_BYTES-byte frame for the I2C byte-sequencing master.
// An optional two's-complement checksum byte goes in the last slot. The
// finished frame is then held stable while tx_enable stays high. tx_enable
// drops when the master reports completion, or when the transmit timeout
// expires, whichever comes first.

module i2c_frame_builder #(
   parameter int NUM_BYTES      = 13,
   parameter int CHECKSUM_EN    = 1,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               byte_in,
   input  logic                     byte_valid,
   input  logic                     byte_last,
   output logic                     byte_ready,
   output logic [8*NUM_BYTES-1:0]   frame_out,
   output logic                     tx_enable,
   input  logic                     tx_complete,
   output logic                     busy,
   output logic [15:0]              frame_count,
   output logic                     err_timeout
);

   localparam int FRAME_W = 8 * NUM_BYTES;
   // Number of slots filled from the stream; the checksum takes the last one.
   localparam int P       = (CHECKSUM_EN != 0) ? NUM_BYTES - 1 : NUM_BYTES;
   localparam int IDX_W   = $clog2(NUM_BYTES + 1);
   localparam int CNT_W   = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      ZPAD    = 2'd1,
      CSUM    = 2'd2,
      WAIT_TX = 2'd3
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic [7:0]        sum;
   logic [CNT_W-1:0]  cnt;

   // The checksum byte makes the modulo-256 sum of the whole frame zero.
   function automatic logic [7:0] csum_byte(input logic [7:0] s);
      return (~s) + 8'd1;
   endfunction

   // byte_ready follows the state only, so a stalled upstream cannot form a
   // combinational loop. It is also gated by reset so that nothing is offered
   // while the block is held in reset.
   always_comb begin
      byte_ready = (state == FILL) && rst;
      busy       = (state != FILL);
   end

   // Frame assembly, checksum, transmit hand-off and timeout sequencing.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= FILL;
         idx         <= '0;
         sum         <= '0;
         cnt         <= '0;
         frame_out   <= '0;
         tx_enable   <= 1'b0;
         frame_count <= '0;
         err_timeout <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (byte_valid) begin
                  // Place the accepted byte in slot idx. Slot 0 is the MSB byte.
                  for (int i = 0; i < NUM_BYTES; i++) begin
                     if (IDX_W'(i) == idx)
                        frame_out[FRAME_W-1-8*i -: 8] <= byte_in;
                  end
                  sum <= sum + byte_in;
                  idx <= idx + 1'b1;
                  if (idx == IDX_W'(P - 1)) begin
                     // The payload is full. A byte_last on this byte adds nothing.
                     if (CHECKSUM_EN != 0) begin
                        state <= CSUM;
                     end else begin
                        state     <= WAIT_TX;
                        tx_enable <= 1'b1;
                     end
                  end else if (byte_last) begin
                     state <= ZPAD;
                  end
               end
            end

            ZPAD: begin
               // Zero every payload slot not yet written. The previous frame's
               // bytes must not leak into this one.
               for (int i = 0; i < P; i++) begin
                  if (IDX_W'(i) >= idx)
                     frame_out[FRAME_W-1-8*i -: 8] <= 8'h00;
               end
               if (CHECKSUM_EN != 0) begin
                  state <= CSUM;
               end else begin
                  state     <= WAIT_TX;
                  tx_enable <= 1'b1;
               end
            end

            CSUM: begin
               frame_out[7:0] <= csum_byte(sum);
               tx_enable      <= 1'b1;
               state          <= WAIT_TX;
            end

            WAIT_TX: begin
               // Completion is checked first so that it wins over a
               // timeout on the same edge.
               if (tx_complete) begin
                  tx_enable   <= 1'b0;
                  frame_count <= frame_count + 16'd1;
                  idx         <= '0;
                  sum         <= '0;
                  cnt         <= '0;
                  state       <= FILL;
               end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  err_timeout <= 1'b1;
                  tx_enable   <= 1'b0;
                  idx         <= '0;
                  sum         <= '0;
                  cnt         <= '0;
                  state       <= FILL;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: begin
               state <= FILL;
            end
         endcase
      end
   end

endmodule
